// File: rtl/md_unit_pkg.sv
// Shared encodings for the multiply/divide unit: MDOp codes, MD-class funct
// codes for the decoder and stall unit, and the HI/LO result pair.
package md_unit_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_NONE6 = 3'd6,
        OP_NONE7 = 3'd7
    } md_op_t;

    // R-type funct field values of the MD-class instructions
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1a;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_result_t;

    function automatic logic is_mult_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

endpackage

// File: rtl/md_unit.sv
// Fixed-latency multiply/divide unit owning HI/LO. The result is computed
// combinationally at Start, held in pending registers and committed when the countdown ends.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic        MDWe,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;
    logic             commit_reg;
    md_result_t       pend_reg;
    logic [31:0]      hi_reg;
    logic [31:0]      lo_reg;

    md_result_t       result_next;
    logic             div_by_zero;
    logic [63:0]      prod_s;
    logic [63:0]      prod_u;
    logic [31:0]      a_mag;
    logic [31:0]      b_mag;
    logic [31:0]      q_mag;
    logic [31:0]      r_mag;

    // Signed division runs on magnitudes; this also yields 0x80000000 / -1 = 0x80000000, rem 0
    always_comb begin
        prod_s      = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u      = {32'd0, A} * {32'd0, B};
        a_mag       = A[31] ? (~A + 32'd1) : A;
        b_mag       = B[31] ? (~B + 32'd1) : B;
        q_mag       = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
        r_mag       = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
        div_by_zero = (B == 32'd0) && !is_mult_op(MDOp);
        result_next = '0;
        case (MDOp)
            OP_MULT:  result_next = {prod_s[63:32], prod_s[31:0]};
            OP_MULTU: result_next = {prod_u[63:32], prod_u[31:0]};
            OP_DIV: begin
                result_next.lo = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
                result_next.hi = A[31] ? (~r_mag + 32'd1) : r_mag;
            end
            OP_DIVU: begin
                result_next.lo = (B == 32'd0) ? 32'd0 : A / B;
                result_next.hi = (B == 32'd0) ? 32'd0 : A % B;
            end
            default: result_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
            commit_reg <= 1'b0;
            pend_reg   <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else if (!busy_reg) begin
            if (Start) begin
                pend_reg   <= result_next;
                commit_reg <= !div_by_zero;
                cnt_reg    <= is_mult_op(MDOp) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                busy_reg   <= 1'b1;
            end else if (MDWe) begin
                if (MDOp == OP_MTHI) hi_reg <= A;
                if (MDOp == OP_MTLO) lo_reg <= A;
            end
        end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) begin
                busy_reg <= 1'b0;
                if (commit_reg) begin
                    hi_reg <= pend_reg.hi;
                    lo_reg <= pend_reg.lo;
                end
            end
        end
    end

    assign Busy = busy_reg;
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes the expected Busy/HI/LO per
// cycle into a queue, a negedge monitor pops and compares.
module tb_md_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Start = 1'b0;
    logic [2:0]  MDOp = 3'd6;
    logic        MDWe = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .MDWe(MDWe),
        .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic        busy;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    logic [31:0] ref_hi = '0;
    logic [31:0] ref_lo = '0;

    // Monitor: compare every expectation due in this cycle
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if (e.due < cyc) begin
                n_bad++;
                $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.due, cyc);
            end else if (Busy !== e.busy || HI !== e.hi || LO !== e.lo) begin
                n_bad++;
                $display("FAIL %s @%0d: got Busy=%0b HI=%08h LO=%08h, want Busy=%0b HI=%08h LO=%08h",
                         e.name, cyc, Busy, HI, LO, e.busy, e.hi, e.lo);
            end else begin
                $display("ok   %s @%0d: Busy=%0b HI=%08h LO=%08h", e.name, cyc, Busy, HI, LO);
            end
        end
    end

    function automatic void push(int due, logic busy, logic [31:0] hi, logic [31:0] lo, string name);
        exp_t e;
        e.due = due; e.busy = busy; e.hi = hi; e.lo = lo; e.name = name;
        exp_q.push_back(e);
    endfunction

    // Reference results straight from the arithmetic definitions
    function automatic logic [63:0] model(logic [2:0] op, logic [31:0] a, logic [31:0] b,
                                          logic [31:0] old_hi, logic [31:0] old_lo);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = {32'd0, a};           ub = {32'd0, b};
        case (op)
            3'd0: return 64'(sa * sb);
            3'd1: return 64'(ua * ub);
            3'd2: begin
                if (b == 0) return {old_hi, old_lo};
                q = sa / sb; r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {old_hi, old_lo};
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk); #2;
    endtask

    // Issue a multiply/divide now; returns one cycle later with Start dropped
    task automatic issue(logic [2:0] op, logic [31:0] a, logic [31:0] b, string name);
        logic [63:0] r;
        int n;
        n = (op < 3'd2) ? MULT_N : DIV_N;
        r = model(op, a, b, ref_hi, ref_lo);
        for (int i = 1; i <= n; i++) push(cyc + i, 1'b1, ref_hi, ref_lo, {name, "_busy"});
        push(cyc + n + 1, 1'b0, r[63:32], r[31:0], {name, "_done"});
        ref_hi = r[63:32]; ref_lo = r[31:0];
        Start = 1'b1; MDOp = op; A = a; B = b;
        tick();
        Start = 1'b0; MDOp = 3'd6; A = $urandom; B = $urandom;
    endtask

    task automatic wait_done(logic [2:0] op);
        int n;
        n = (op < 3'd2) ? MULT_N : DIV_N;
        repeat (n) tick();
    endtask

    task automatic run(logic [2:0] op, logic [31:0] a, logic [31:0] b, string name);
        issue(op, a, b, name);
        wait_done(op);
    endtask

    task automatic mtx(logic [2:0] op, logic [31:0] a, string name);
        if (op == 3'd4) ref_hi = a; else ref_lo = a;
        push(cyc + 1, 1'b0, ref_hi, ref_lo, name);
        MDWe = 1'b1; MDOp = op; A = a;
        tick();
        MDWe = 1'b0; MDOp = 3'd6;
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int          guard;

        tick();
        reset = 1'b0;
        push(cyc, 1'b0, 32'd0, 32'd0, "reset");
        push(cyc + 1, 1'b0, 32'd0, 32'd0, "reset_idle");
        tick(); tick();

        run(3'd0, 32'hFFFF_FFFE, 32'd3, "mult_neg");
        run(3'd2, -32'sd7, 32'd2, "div_neg");
        run(3'd3, 32'd7, 32'd0, "divu_by0");
        mtx(3'd4, 32'h1234_5678, "mthi");
        mtx(3'd5, 32'h9ABC_DEF0, "mtlo");

        // MDWe during a MULT must be ignored
        issue(3'd0, 32'd100, 32'd7, "mult_guard");
        MDWe = 1'b1; MDOp = 3'd4; A = 32'hDEAD_BEEF;
        tick();
        MDWe = 1'b0; MDOp = 3'd6;
        repeat (MULT_N - 1) tick();

        run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");

        // Reset at cycle 3 of a DIV: drop its expectations, expect no later commit
        issue(3'd2, 32'd1000, 32'd3, "div_abort");
        tick();
        reset = 1'b1;
        while (exp_q.size() > 0 && exp_q[$].due >= cyc + 1) void'(exp_q.pop_back());
        ref_hi = '0; ref_lo = '0;
        for (int i = 1; i <= DIV_N + 2; i++) push(cyc + i, 1'b0, 32'd0, 32'd0, "abort_idle");
        tick();
        reset = 1'b0;
        repeat (DIV_N + 2) tick();

        run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run(3'd0, 32'd6, 32'hFFFF_FFF9, "mult_b2b");

        for (int k = 0; k < 40; k++) begin
            op = 3'($urandom_range(0, 5));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = b & 32'h0000_00FF;
            if (op >= 3'd4) mtx(op, a, "rnd_mt");
            else run(op, a, b, "rnd_op");
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 50) begin
            tick();
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
